vga_pixel_stream: RTL and testbench



---
 rtl/vga_pixel_stream.sv | 111 +++++++++++
 tb/tb_vga_pixel_stream.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_stream.sv
// rtl/vga_pixel_stream.sv - FIFO-fed VGA pixel generator with registered output and underflow resync
// Optional feature: define VGA_PATTERN_EN to enable the colour-bar PATTERN mode.
module vga_pixel_stream #(
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter int          CW       = 8,
  parameter logic [29:0] FILL_RGB = 30'h0
) (
  input  logic          VGA_CLK,
  input  logic          a_reset,
  input  logic [11:0]   dx,
  input  logic [11:0]   dy,
  input  logic [31:0]   fifo_data,
  input  logic          fifo_valid,
  output logic          fifo_ready,
  input  logic [1:0]    mode,
  output logic          frame_start,
  output logic [15:0]   underflow_cnt,
  output logic          VGA_BLANK_N,
  output logic [CW-1:0] VGA_R,
  output logic [CW-1:0] VGA_G,
  output logic [CW-1:0] VGA_B
);

  typedef enum logic [1:0] {SYNC_WAIT, STREAM, RESYNC} state_t;

  localparam int          PW       = 3 * CW;
  localparam logic [1:0]  M_STREAM = 2'd0;
  localparam logic [1:0]  M_FILL   = 2'd1;
  localparam logic [11:0] H_LIM    = 12'(H_ACTIVE);
  localparam logic [11:0] V_LIM    = 12'(V_ACTIVE);
  localparam logic [PW-1:0] FILL_PIX = FILL_RGB[PW-1:0];

  state_t        state, state_nxt;
  logic [1:0]    mode_q;
  logic [1:0]    eff_mode;
  logic          active, fs, pop, underflow;
  logic [PW-1:0] pix_nxt, pix_q;
  logic          unused_hi;

  assign unused_hi  = ^fifo_data[31:PW];

  assign active     = (dx < H_LIM) && (dy < V_LIM);
  assign fs         = (dx == 12'd0) && (dy == 12'd0);
  // The new mode is already in force on the frame-start cycle itself.
  assign eff_mode   = fs ? mode : mode_q;
  assign fifo_ready = !a_reset && active && (eff_mode == M_STREAM) &&
                      ((state == STREAM) || fs);
  assign pop        = fifo_ready && fifo_valid;
  assign underflow  = fifo_ready && !fifo_valid;

`ifdef VGA_PATTERN_EN
  localparam logic [1:0] M_PATTERN = 2'd2;
  logic [2:0]    bar;
  logic [PW-1:0] bar_pix;

  // Bar index = (dx*8)/H_ACTIVE as a chain of constant compares feeding the output register.
  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if ({1'b0, dx, 3'b000} >= 16'(k * H_ACTIVE)) bar = bar + 3'd1;
    end
    bar_pix = {{CW{~bar[1]}}, {CW{~bar[2]}}, {CW{~bar[0]}}};
  end
`endif

  always_ff @(posedge VGA_CLK) begin
    if (a_reset) begin
      state         <= SYNC_WAIT;
      mode_q        <= M_FILL;
      underflow_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      if (fs) mode_q <= mode;
      if (underflow && (underflow_cnt != 16'hFFFF)) underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (pop)            state_nxt = STREAM;
    else if (underflow) state_nxt = RESYNC;
  end

  always_comb begin
    pix_nxt = '0;
    if (pop)
      pix_nxt = fifo_data[PW-1:0];
`ifdef VGA_PATTERN_EN
    else if (active && (eff_mode == M_PATTERN))
      pix_nxt = bar_pix;
`endif
    else if (active)
      pix_nxt = FILL_PIX;
  end

  always_ff @(posedge VGA_CLK) begin
    if (a_reset) begin
      pix_q       <= '0;
      VGA_BLANK_N <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_q       <= pix_nxt;
      VGA_BLANK_N <= active;
      frame_start <= fs;
    end
  end

  assign {VGA_R, VGA_G, VGA_B} = pix_q;

endmodule

// File: tb/tb_vga_pixel_stream.sv
// tb/tb_vga_pixel_stream.sv - scoreboard bench for vga_pixel_stream on a reduced 40x3 raster
module tb_vga_pixel_stream;

  localparam int H  = 40;
  localparam int V  = 3;
  localparam int HT = 44;
  localparam int VT = 4;
  localparam logic [29:0] FILL = 30'h3F123456;
  localparam logic [23:0] FPIX = 24'h123456;
  localparam int K_STREAM = 0;
  localparam int K_FILL   = 1;

  logic        clk = 1'b0;
  logic        a_reset = 1'b1;
  logic [11:0] dx = '0, dy = '0;
  logic [31:0] fifo_data = '0;
  logic        fifo_valid = 1'b0;
  logic        fifo_ready;
  logic [1:0]  mode = 2'd0;
  logic        frame_start;
  logic [15:0] underflow_cnt;
  logic        VGA_BLANK_N;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  typedef struct packed {
    logic        blank;
    logic [23:0] rgb;
    logic        fs;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pops     = 0;
  int   seq      = 0;
  int   exp_ucnt = 0;

  vga_pixel_stream #(.H_ACTIVE(H), .V_ACTIVE(V), .CW(8), .FILL_RGB(FILL)) dut (
    .VGA_CLK(clk), .a_reset(a_reset), .dx(dx), .dy(dy),
    .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_ready(fifo_ready),
    .mode(mode), .frame_start(frame_start), .underflow_cnt(underflow_cnt),
    .VGA_BLANK_N(VGA_BLANK_N), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (dx=%0d dy=%0d t=%0t)", name, act, exp, dx, dy, $time);
    end
  endtask

  always @(posedge clk) if (!a_reset && fifo_ready && fifo_valid) pops++;

  // Monitor: each negedge shows the registered result of the previous cycle's inputs.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pixel{blank,rgb,fs}", {6'b0, VGA_BLANK_N, VGA_R, VGA_G, VGA_B, frame_start}, {6'b0, e});
    end
  end

  task automatic step(input int x, input int y, input logic v, input logic [31:0] d,
                      input logic [1:0] md, input logic rst, input logic e_rdy,
                      input logic [23:0] e_rgb);
    logic act;
    exp_t e;
    @(negedge clk);
    dx = 12'(x); dy = 12'(y); fifo_valid = v; fifo_data = d; mode = md; a_reset = rst;
    #1;
    act = !rst && (x < H) && (y < V);
    check("fifo_ready", {31'b0, fifo_ready}, {31'b0, e_rdy});
    e.blank = act;
    e.rgb   = act ? e_rgb : 24'h0;
    e.fs    = !rst && (x == 0) && (y == 0);
    exp_q.push_back(e);
  endtask

  task automatic check_ucnt();
    @(posedge clk);
    #1;
    check("underflow_cnt", {16'b0, underflow_cnt}, 32'(exp_ucnt));
  endtask

  function automatic logic [31:0] next_word();
    seq++;
    return {8'hC3, 24'(seq * 32'h00010307)};
  endfunction

  // One full raster; mode switches from md0 to md1 at (sw_x, sw_y); fifo_valid low at (drop_x, drop_y).
  task automatic frame(input int kind, input int drop_x, input int drop_y,
                       input logic [1:0] md0, input logic [1:0] md1,
                       input int sw_x, input int sw_y);
    logic        popping;
    logic        act, v;
    logic [1:0]  md;
    logic [31:0] d;
    int          p0, exp_pops;
    popping  = (kind == K_STREAM);
    p0       = pops;
    exp_pops = 0;
    for (int y = 0; y < VT; y++) begin
      for (int x = 0; x < HT; x++) begin
        md  = ((y > sw_y) || (y == sw_y && x >= sw_x)) ? md1 : md0;
        act = (x < H) && (y < V);
        v   = !(x == drop_x && y == drop_y);
        d   = next_word();
        if (popping && act) begin
          if (v) begin
            step(x, y, 1'b1, d, md, 1'b0, 1'b1, d[23:0]);
            exp_pops++;
          end else begin
            step(x, y, 1'b0, d, md, 1'b0, 1'b1, FPIX);
            popping = 1'b0;
            exp_ucnt++;
          end
        end else begin
          step(x, y, v, d, md, 1'b0, 1'b0, FPIX);
        end
      end
    end
    check("frame_pops", 32'(pops - p0), 32'(exp_pops));
    check_ucnt();
  endtask

  localparam logic [23:0] WHITE = 24'hFFFFFF, YELLOW = 24'hFFFF00, CYAN = 24'h00FFFF,
                          GREEN = 24'h00FF00, MAGENTA = 24'hFF00FF, RED = 24'hFF0000,
                          BLUE = 24'h0000FF, BLACK = 24'h000000;

  int          pat_x[10] = '{0, 4, 5, 10, 17, 20, 29, 30, 39, 2};
`ifdef VGA_PATTERN_EN
  logic [23:0] pat_c[10] = '{WHITE, WHITE, YELLOW, CYAN, GREEN, MAGENTA, RED, BLUE, BLACK, WHITE};
`else
  logic [23:0] pat_c[10] = '{FPIX, FPIX, FPIX, FPIX, FPIX, FPIX, FPIX, FPIX, FPIX, FPIX};
`endif

  initial begin
    int p0;
    // Reset held three cycles mid-frame with a valid FIFO.
    for (int i = 0; i < 3; i++) step(10 + i, 1, 1'b1, next_word(), 2'd0, 1'b1, 1'b0, 24'h0);
    p0 = pops;
    for (int p = HT + 13; p < HT * VT; p++)
      step(p % HT, p / HT, 1'b1, next_word(), 2'd0, 1'b0, 1'b0, FPIX);
    check("pops_before_sync", 32'(pops - p0), 32'd0);
    check_ucnt();

    frame(K_STREAM, -1, -1, 2'd0, 2'd0, 0, 0);   // first synced frame, all pixels streamed
    frame(K_STREAM, 10,  2, 2'd0, 2'd0, 0, 0);   // mid-frame underflow
    frame(K_STREAM, -1, -1, 2'd0, 2'd0, 0, 0);   // recovers at the next frame start
    frame(K_STREAM, 39,  2, 2'd0, 2'd0, 0, 0);   // underflow on the last active pixel
    frame(K_STREAM,  0,  0, 2'd0, 2'd0, 0, 0);   // underflow on the frame-start pixel
    frame(K_STREAM, -1, -1, 2'd0, 2'd1, 8, 1);   // FILL requested mid-frame, streaming continues
    frame(K_FILL,   -1, -1, 2'd1, 2'd0, 5, 1);   // FILL frame; STREAM requested mid-frame
    frame(K_STREAM, -1, -1, 2'd0, 2'd0, 0, 0);   // popping resumes at frame start

    // PATTERN mode latched at frame start, then directed bar positions.
    step(0, 0, 1'b1, next_word(), 2'd2, 1'b0, 1'b0, pat_c[0]);
    for (int i = 0; i < 10; i++) step(pat_x[i], 1, 1'b1, next_word(), 2'd2, 1'b0, 1'b0, pat_c[i]);
    step(40, 1, 1'b1, next_word(), 2'd2, 1'b0, 1'b0, 24'h0);
    check_ucnt();

    // Every cycle at (0,0) with an empty FIFO is an underflow; drive the counter to saturation.
    for (int i = exp_ucnt; i < 65535; i++) step(0, 0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, FPIX);
    exp_ucnt = 65535;
    check_ucnt();
    step(0, 0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, FPIX);
    check_ucnt();

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "time limit");
  end

endmodule
